// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: execute vs. memory results into one register-file write port.
// Optional RISCV_WB_BYPASS_EN adds forwarding of the registered write to two read ports.
module riscv_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec_valid_i,
  input  logic [4:0]  exec_rd_i,
  input  logic [31:0] exec_value_i,
  output logic        exec_ready_o,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [31:0] mem_value_i,
  output logic        mem_ready_o,
  output logic [4:0]  rd0_o,
  output logic [31:0] rd0_value_o,
  output logic        starve_o
`ifdef RISCV_WB_BYPASS_EN
  ,
  input  logic [4:0]  ra0_i,
  input  logic [4:0]  rb0_i,
  input  logic [31:0] ra0_value_i,
  input  logic [31:0] rb0_value_i,
  output logic [31:0] ra0_value_o,
  output logic [31:0] rb0_value_o
`endif
);

  typedef enum logic {
    MEM_PRI,
    EXEC_PRI
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       exec_real;
  logic       mem_real;
  logic       grant_exec;
  logic       grant_mem;

  assign exec_real = exec_valid_i && (exec_rd_i != 5'd0);
  assign mem_real  = mem_valid_i && (mem_rd_i != 5'd0);

  always_comb begin
    grant_exec = 1'b0;
    grant_mem  = 1'b0;
    case (state)
      MEM_PRI: begin
        grant_mem  = mem_real;
        grant_exec = exec_real && !mem_real;
      end
      EXEC_PRI: begin
        grant_exec = exec_real;
        grant_mem  = mem_real && !exec_real;
      end
      default: begin
        grant_exec = 1'b0;
        grant_mem  = 1'b0;
      end
    endcase
  end

  // Null requests are absorbed immediately without using the write port.
  assign exec_ready_o = !rst &&
    (grant_exec || (exec_valid_i && exec_rd_i == 5'd0));
  assign mem_ready_o = !rst &&
    (grant_mem || (mem_valid_i && mem_rd_i == 5'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MEM_PRI;
      starve_cnt  <= 4'd0;
      rd0_o       <= 5'd0;
      rd0_value_o <= 32'd0;
      starve_o    <= 1'b0;
    end else begin
      if (grant_exec) begin
        rd0_o       <= exec_rd_i;
        rd0_value_o <= exec_value_i;
      end else if (grant_mem) begin
        rd0_o       <= mem_rd_i;
        rd0_value_o <= mem_value_i;
      end else begin
        rd0_o       <= 5'd0;
        rd0_value_o <= 32'd0;
      end
      case (state)
        MEM_PRI: begin
          if (grant_mem && exec_real) begin
            if (starve_cnt + 4'd1 == LIMIT) begin
              state      <= EXEC_PRI;
              starve_cnt <= 4'd0;
              starve_o   <= 1'b1;
            end else begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else begin
            starve_cnt <= 4'd0;
          end
        end
        EXEC_PRI: begin
          if (grant_exec || !exec_real) begin
            state      <= MEM_PRI;
            starve_cnt <= 4'd0;
            starve_o   <= 1'b0;
          end
        end
        default: begin
          state      <= MEM_PRI;
          starve_cnt <= 4'd0;
          starve_o   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RISCV_WB_BYPASS_EN
  assign ra0_value_o = (ra0_i == rd0_o && rd0_o != 5'd0) ?
    rd0_value_o : ra0_value_i;
  assign rb0_value_o = (rb0_i == rd0_o && rd0_o != 5'd0) ?
    rd0_value_o : rb0_value_i;
`endif

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Randomized bench for riscv_wb_arbiter against a cycle-level reference model.
// Directed sequences first, then held-request random traffic with sporadic reset.
module tb_riscv_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        exec_valid_i;
  logic [4:0]  exec_rd_i;
  logic [31:0] exec_value_i;
  logic        exec_ready_o;
  logic        mem_valid_i;
  logic [4:0]  mem_rd_i;
  logic [31:0] mem_value_i;
  logic        mem_ready_o;
  logic [4:0]  rd0_o;
  logic [31:0] rd0_value_o;
  logic        starve_o;
`ifdef RISCV_WB_BYPASS_EN
  logic [4:0]  ra0_i = '0;
  logic [4:0]  rb0_i = '0;
  logic [31:0] ra0_value_i = '0;
  logic [31:0] rb0_value_i = '0;
  logic [31:0] ra0_value_o;
  logic [31:0] rb0_value_o;
`endif

  riscv_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .exec_valid_i(exec_valid_i),
    .exec_rd_i(exec_rd_i),
    .exec_value_i(exec_value_i),
    .exec_ready_o(exec_ready_o),
    .mem_valid_i(mem_valid_i),
    .mem_rd_i(mem_rd_i),
    .mem_value_i(mem_value_i),
    .mem_ready_o(mem_ready_o),
    .rd0_o(rd0_o),
    .rd0_value_o(rd0_value_o),
    .starve_o(starve_o)
`ifdef RISCV_WB_BYPASS_EN
    ,
    .ra0_i(ra0_i),
    .rb0_i(rb0_i),
    .ra0_value_i(ra0_value_i),
    .rb0_value_i(rb0_value_i),
    .ra0_value_o(ra0_value_o),
    .rb0_value_o(rb0_value_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who currently has priority and how long exec has waited.
  bit          m_exec_first = 1'b0;
  int          m_waits = 0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_val = '0;
  bit          e_acc;
  bit          m_acc;
  int          exec_grants;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r,
                      input bit ev, input logic [4:0] erd,
                      input logic [31:0] evl,
                      input bit mv, input logic [4:0] mrd,
                      input logic [31:0] mvl);
    int  win;
    bit  er;
    bit  mr;
    rst          = r;
    exec_valid_i = ev;
    exec_rd_i    = erd;
    exec_value_i = evl;
    mem_valid_i  = mv;
    mem_rd_i     = mrd;
    mem_value_i  = mvl;
    er  = ev && erd != 0;
    mr  = mv && mrd != 0;
    win = 0;
    if (!r) begin
      if (er && mr) win = m_exec_first ? 1 : 2;
      else if (er) win = 1;
      else if (mr) win = 2;
    end
    e_acc = !r && (win == 1 || (ev && erd == 0));
    m_acc = !r && (win == 2 || (mv && mrd == 0));
    #1;
    check("exec_ready", exec_ready_o, e_acc);
    check("mem_ready", mem_ready_o, m_acc);
    if (win == 1) exec_grants++;
    if (r) begin
      m_exec_first = 1'b0;
      m_waits = 0;
      exp_rd  = '0;
      exp_val = '0;
    end else begin
      exp_rd  = (win == 1) ? erd : (win == 2) ? mrd : 5'd0;
      exp_val = (win == 1) ? evl : (win == 2) ? mvl : 32'd0;
      if (m_exec_first) begin
        if (win == 1 || !er) m_exec_first = 1'b0;
      end else if (win == 2 && er) begin
        m_waits++;
        if (m_waits == LIMIT) begin
          m_exec_first = 1'b1;
          m_waits = 0;
        end
      end else begin
        m_waits = 0;
      end
    end
    @(posedge clk);
    #1;
    check("rd0", rd0_o, exp_rd);
    check("rd0_value", rd0_value_o, exp_val);
    check("starve", starve_o, m_exec_first);
  endtask

  bit          ev;
  logic [4:0]  erd;
  logic [31:0] evl;
  bit          mv;
  logic [4:0]  mrd;
  logic [31:0] mvl;

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0);

    // Lone exec write, then idle.
    step(0, 1, 5, 32'h1234, 0, 0, 0);
    check("lone_rd", rd0_o, 5);
    check("lone_val", rd0_value_o, 32'h1234);
    step(0, 0, 0, 0, 0, 0, 0);
    check("lone_clear", rd0_o, 0);

    // Contention: mem first, held exec next.
    step(0, 1, 3, 32'h33, 1, 7, 32'h77);
    check("both_first", rd0_o, 7);
    step(0, 1, 3, 32'h33, 0, 0, 0);
    check("both_second", rd0_o, 3);

    // Starvation: exec rd 9 waits behind continuous mem traffic.
    exec_grants = 0;
    for (int i = 0; i < LIMIT; i++)
      step(0, 1, 9, 32'h99, 1, 5'(i + 1), 32'(i));
    check("starve_hi", starve_o, 1);
    step(0, 1, 9, 32'h99, 1, 12, 32'hC);
    check("starve_exec", rd0_o, 9);
    check("starve_grants", exec_grants, 1);
    step(0, 0, 0, 0, 1, 12, 32'hC);
    check("starve_resume", rd0_o, 12);

    // Null exec beside real mem.
    step(0, 1, 0, 32'hDEAD, 1, 4, 32'h44);
    check("null_rd", rd0_o, 4);

    // Reset right after a grant.
    step(0, 1, 8, 32'h88, 0, 0, 0);
    step(1, 1, 8, 32'h88, 1, 2, 32'h22);
    check("rst_drop", rd0_o, 0);
    step(0, 1, 8, 32'h88, 1, 2, 32'h22);
    check("post_rst", rd0_o, 2);

`ifdef RISCV_WB_BYPASS_EN
    step(0, 0, 0, 0, 1, 6, 32'hAA);
    ra0_i = 6;
    ra0_value_i = 32'h11;
    rb0_i = 0;
    rb0_value_i = 32'h55;
    #1;
    check("byp_a", ra0_value_o, 32'hAA);
    check("byp_b", rb0_value_o, 32'h55);
    ra0_i = 0;
    #1;
    check("byp_a0", ra0_value_o, 32'h11);
`endif

    // Random traffic; requesters hold until accepted.
    ev = 0; erd = 0; evl = 0;
    mv = 0; mrd = 0; mvl = 0;
    for (int c = 0; c < 600; c++) begin
      if (!ev || e_acc) begin
        ev  = ($urandom % 3) != 0;
        erd = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom);
        evl = $urandom;
      end
      if (!mv || m_acc) begin
        mv  = ($urandom % 4) != 0;
        mrd = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom);
        mvl = $urandom;
      end
      step(($urandom % 40) == 0, ev, erd, evl, mv, mrd, mvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the maximum consecutive mem grants while exec waits (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 exec_valid_i  input  1  execute-stage writeback request.
REQ-005 exec_rd_i  input  5  execute destination register.
REQ-006 exec_value_i  input  32  execute result.
REQ-007 exec_ready_o  output  1  execute request accepted this cycle.
REQ-008 mem_valid_i  input  1  load/long-latency unit writeback request.
REQ-009 mem_rd_i  input  5  mem destination register.
REQ-010 mem_value_i  input  32  mem result.
REQ-011 mem_ready_o  output  1  mem request accepted this cycle.
REQ-012 rd0_o  output  5  register-file write index, registered; 0 means no write.
REQ-013 rd0_value_o  output  32  register-file write data, registered.
REQ-014 starve_o  output  1  high while in EXEC_PRI state.
REQ-015 With RISCV_WB_BYPASS_EN only: ra0_i, rb0_i input 5; ra0_value_i, rb0_value_i input 32 from register file; ra0_value_o, rb0_value_o output 32 bypassed read data.

Function
REQ-016 A request is "real" when valid=1 and rd!=0; a "null" request is valid=1 and rd=0.
REQ-017 A null request SHALL be accepted (ready=1) in the same cycle, never consume the port, and never alter rd0_o.
REQ-018 At most one real request SHALL be granted per cycle; ready_o outputs are combinational from current inputs and state.
REQ-019 A granted request SHALL appear on rd0_o/rd0_value_o on the next rising edge (one-cycle latency) and hold for exactly one cycle.
REQ-020 In a cycle with no real grant, rd0_o SHALL be 0 on the next edge; rd0_value_o SHALL be 0.
REQ-021 States: MEM_PRI (reset state) and EXEC_PRI.
REQ-022 MEM_PRI: real mem wins over real exec; lone real request of either source is granted.
REQ-023 MEM_PRI: 4-bit starve counter increments when mem is granted while real exec is waiting; clears when exec is granted or exec is not real.
REQ-024 MEM_PRI -> EXEC_PRI when the counter increment reaches STARVE_LIMIT; counter clears on the transition.
REQ-025 EXEC_PRI: real exec wins over real mem; on exec grant, or if exec is not real, return to MEM_PRI next cycle.
REQ-026 Non-granted real requester SHALL see ready=0 and hold its request; holding is the requester's obligation.
REQ-027 Both sources real with equal rd: arbitration unchanged; writes occur in grant order.
REQ-028 Reset asserted mid-operation SHALL drop any in-flight registered write (rd0_o forced 0 on that edge).

Reset
REQ-029 On rst=1 at a rising edge: state=MEM_PRI, starve counter=0, rd0_o=0, rd0_value_o=0, starve_o=0.
REQ-030 While rst=1, exec_ready_o and mem_ready_o SHALL be 0, including for null requests.

Configuration
REQ-031 Macro RISCV_WB_BYPASS_EN defined: ra0_value_o = rd0_value_o when ra0_i==rd0_o and rd0_o!=0, else ra0_value_i; rb0 identical.
REQ-032 Macro undefined: bypass ports absent; arbitration behaviour identical.

Verification
REQ-033 Exec only rd=5 value 0x1234 -> exec_ready_o=1 same cycle; rd0_o=5, rd0_value_o=0x1234 next cycle; rd0_o=0 the cycle after.
REQ-034 Exec rd=3 and mem rd=7 both valid, held -> mem granted first, exec granted next cycle; writes 7 then 3.
REQ-035 STARVE_LIMIT=4, mem continuously real, exec rd=9 held -> 4 mem grants, starve_o=1, exec granted on 5th cycle, then mem resumes.
REQ-036 Exec rd=0 with mem rd=4 -> both ready=1 same cycle; only register 4 written.
REQ-037 rst pulsed in the cycle after a grant -> rd0_o=0, readies 0 during reset, state MEM_PRI afterward.
REQ-038 Bypass build: rd0_o=6 value 0xAA, ra0_i=6, ra0_value_i=0x11 -> ra0_value_o=0xAA; ra0_i=0 -> ra0_value_i passed through.
